// File: rtl/x_pkg.sv
// x_pkg: shared state type and default sizes for the load arbiter.
package x_pkg;
    localparam int NREQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [2:0] {INIT, IDLE, LOAD, CHECK, RESP} state_t;
endpackage

// File: rtl/x_rr_pick.sv
// x_rr_pick: circular first-set pick starting at ptr, one-hot grant plus index.
module x_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    logic [IW-1:0] j;
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        j = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx = j;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/x_load_arb.sv
// x_load_arb: round-robin arbiter that loads a shared register, reads it back
// and returns the readback with a mismatch flag to the granted requester.
module x_load_arb
    import x_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [WIDTH-1:0]         x_din,
    output logic                     x_load,
    input  logic [WIDTH-1:0]         x_dout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);
    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [IW-1:0]   rr_ptr, lat_id, pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any;
    logic [WIDTH-1:0] lat_data, din_q;
    logic            init_drive;

    x_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(req_valid),
        .ptr(rr_ptr),
        .grant(pick_grant),
        .idx(pick_idx),
        .any(pick_any)
    );

    // INIT is also the reset state, so its load is suppressed while reset is held
    assign init_drive = (state == INIT) && !reset;
    assign req_ready = (state == IDLE) ? pick_grant : '0;
    assign x_load = init_drive || (state == LOAD);
    assign x_din = init_drive ? CLR_VAL : (state == LOAD) ? lat_data : din_q;
    assign busy = state != IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_id = lat_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            rr_ptr <= '0;
            lat_id <= '0;
            lat_data <= '0;
            din_q <= '0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    din_q <= CLR_VAL;
                    state <= IDLE;
                end
                IDLE: if (pick_any) begin
                    lat_data <= req_data[pick_idx*WIDTH +: WIDTH];
                    lat_id <= pick_idx;
                    rr_ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    din_q <= lat_data;
                    state <= CHECK;
                end
                CHECK: begin
                    rsp_data <= x_dout;
                    rsp_err <= x_dout != lat_data;
                    state <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x_load_arb.sv
// tb_x_load_arb: randomized and directed stimulus against a transaction-level
// round-robin model; a negedge monitor checks responses from a scoreboard queue.
module tb_x_load_arb;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_valid, req_ready;
    logic [31:0] req_data;
    logic [7:0] x_din, x_dout, rsp_data;
    logic       x_load, rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0] rsp_id;
    logic [7:0] rd[4];
    logic [7:0] xreg = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign req_data = {rd[3], rd[2], rd[1], rd[0]};
    assign x_dout = xreg;

    // register model: a load of 8'h3C is corrupted to 8'h00
    always @(posedge clk) if (x_load) xreg <= (x_din == 8'h3C) ? 8'h00 : x_din;

    x_load_arb #(.NREQ(4), .WIDTH(8), .CLR_VAL(8'h00)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .x_din(x_din), .x_load(x_load), .x_dout(x_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(bit ok, string name, int act, int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    typedef struct {int id; logic [7:0] rdata; bit err;} exp_t;
    exp_t sb[$];
    exp_t cur;
    int   glog[$];
    bit   outstanding = 0, seen = 0, in_init = 0;
    int   cyc = 0, acc_cyc = 0, m_ptr = 0, rsp_done = 0, g;
    logic [7:0] ld_data = 8'h00, last_din = 8'h00, d;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            outstanding = 0;
            seen = 0;
            in_init = 1;
            m_ptr = 0;
        end else if (in_init) begin
            chk(x_load == 1'b1, "init_load", x_load, 1);
            chk(x_din == 8'h00, "init_din", x_din, 0);
            chk(busy == 1'b1, "init_busy", busy, 1);
            chk(req_ready == 4'b0, "init_ready", req_ready, 0);
            last_din = 8'h00;
            in_init = 0;
        end else begin
            chk(busy == outstanding, "busy", busy, outstanding);
            if (outstanding && cyc == acc_cyc + 1) begin
                chk(x_load == 1'b1, "load_strobe", x_load, 1);
                chk(x_din == ld_data, "load_din", x_din, ld_data);
                last_din = ld_data;
            end else begin
                chk(x_load == 1'b0, "load_idle", x_load, 0);
                chk(x_din == last_din, "din_hold", x_din, last_din);
            end
            if (req_ready != 4'b0) begin
                g = pick(req_valid, m_ptr);
                chk(!outstanding, "accept_busy", req_ready, 0);
                chk(g >= 0 && req_ready == (4'b1 << g), "grant", req_ready, (g >= 0) ? (1 << g) : 0);
                if (g >= 0) begin
                    d = req_data[g*8 +: 8];
                    ld_data = d;
                    sb.push_back('{id: g, rdata: (d == 8'h3C) ? 8'h00 : d, err: d == 8'h3C});
                    glog.push_back(g);
                    m_ptr = (g + 1) % 4;
                end
                acc_cyc = cyc;
                outstanding = 1;
                seen = 0;
            end else if (!outstanding && req_valid != 4'b0) begin
                chk(0, "missed_accept", 0, req_valid);
            end
            if (rsp_valid) begin
                if (!outstanding) chk(0, "spurious_rsp", 1, 0);
                else begin
                    if (!seen) begin
                        chk(cyc - acc_cyc == 3, "latency", cyc - acc_cyc, 3);
                        if (sb.size() > 0) cur = sb.pop_front();
                        seen = 1;
                    end
                    chk(rsp_id == cur.id, "rsp_id", rsp_id, cur.id);
                    chk(rsp_data == cur.rdata, "rsp_data", rsp_data, cur.rdata);
                    chk(rsp_err == cur.err, "rsp_err", rsp_err, cur.err);
                    if (rsp_ready) begin
                        outstanding = 0;
                        rsp_done++;
                    end
                end
            end else if (outstanding && seen) begin
                chk(0, "rsp_dropped", 0, 1);
            end else if (outstanding && cyc > acc_cyc + 3) begin
                chk(0, "rsp_late", cyc - acc_cyc, 3);
            end
        end
        cyc++;
    end

    logic [3:0] acc;
    bit refill = 0, rmode = 0;

    task automatic tick();
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) begin
            req_valid[i] = 1'b0;
            if (refill) begin
                req_valid[i] = 1'b1;
                rd[i] = rd[i] + 8'h44;
            end
        end
        if (rmode) begin
            for (int i = 0; i < 4; i++) if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                req_valid[i] = 1'b1;
                rd[i] = 8'($urandom_range(0, 255));
            end
            rsp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_acc(int budget, string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (acc == 4'b0 && n < budget);
        chk(acc != 4'b0, name, acc, 1);
    endtask

    int n0, g0, n;

    initial begin
        req_valid = 4'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) rd[i] = 8'h00;
        #12;
        chk(req_ready == 4'b0, "rst_ready", req_ready, 0);
        chk(x_load == 1'b0, "rst_load", x_load, 0);
        chk(x_din == 8'h00, "rst_din", x_din, 0);
        chk(rsp_valid == 1'b0, "rst_rsp_valid", rsp_valid, 0);
        chk(rsp_id == 2'd0, "rst_rsp_id", rsp_id, 0);
        chk(rsp_data == 8'h00, "rst_rsp_data", rsp_data, 0);
        chk(rsp_err == 1'b0, "rst_rsp_err", rsp_err, 0);
        chk(busy == 1'b1, "rst_busy", busy, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk(x_load == 1'b1 && x_din == 8'h00, "rel_init", {x_load, x_din}, 9'h100);
        @(negedge clk);
        chk(busy == 1'b0, "rel_idle", busy, 0);
        @(posedge clk); #1;

        rd[2] = 8'hA5;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        wait_acc(10, "single_acc");
        chk(acc == 4'b0100, "single_grant", acc, 4'b0100);
        repeat (6) tick();
        chk(rsp_done == 1, "single_done", rsp_done, 1);

        rd[0] = 8'h77;
        req_valid = 4'b0001;
        wait_acc(10, "abort_acc");
        reset = 1'b1;
        req_valid = 4'b0;
        #1;
        chk(req_ready == 4'b0, "abort_ready", req_ready, 0);
        chk(x_load == 1'b0, "abort_load", x_load, 0);
        chk(x_din == 8'h00, "abort_din", x_din, 0);
        chk(rsp_valid == 1'b0, "abort_rsp_valid", rsp_valid, 0);
        chk(rsp_id == 2'd0, "abort_rsp_id", rsp_id, 0);
        chk(rsp_data == 8'h00, "abort_rsp_data", rsp_data, 0);
        chk(busy == 1'b1, "abort_busy", busy, 1);
        n0 = rsp_done;
        g0 = glog.size();
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk(x_load == 1'b1 && x_din == 8'h00, "abort_init", {x_load, x_din}, 9'h100);
        @(posedge clk); #1;
        repeat (5) tick();
        chk(rsp_done == n0, "abort_no_rsp", rsp_done, n0);
        chk(glog.size() == g0, "abort_no_regrant", glog.size(), g0);

        glog.delete();
        rd[0] = 8'h10; rd[1] = 8'h21; rd[2] = 8'h32; rd[3] = 8'h43;
        refill = 1;
        req_valid = 4'b1111;
        n = 0;
        while (glog.size() < 5 && n < 60) begin
            tick();
            n++;
        end
        refill = 0;
        req_valid = 4'b0;
        chk(glog.size() >= 5, "rr_count", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++) chk(glog[k] == k % 4, "rr_order", glog[k], k % 4);
        repeat (6) tick();

        rd[0] = 8'h3C;
        req_valid = 4'b0001;
        wait_acc(10, "corrupt_acc");
        repeat (6) tick();

        rd[1] = 8'h5A;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        wait_acc(10, "stall_acc");
        repeat (2) tick();
        rd[3] = 8'hE1;
        req_valid = 4'b1000;
        repeat (10) tick();
        chk(rsp_valid == 1'b1, "stall_hold", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        tick();
        chk(acc == 4'b1000, "stall_next", acc, 4'b1000);
        repeat (6) tick();

        rmode = 1;
        repeat (400) tick();
        rmode = 0;
        req_valid = 4'b0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk(sb.size() == 0, "sb_drain", sb.size(), 0);
        chk(!outstanding, "final_idle", outstanding, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
